// File: rtl/run_dispatcher_pkg.sv
// Shared state encoding and default sizing for the run dispatcher.
package run_dispatch_pkg;

  localparam int DEF_NUM_W     = 4;
  localparam int DEF_JOB_W     = 4;
  localparam int DEF_TO_CYCLES = 64;

  // ST_ERR is only reachable when the WAIT timeout is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_ERR    = 3'd4
  } run_state_e;

endpackage

// File: rtl/run_dispatcher_if.sv
// Command handshake between a requester (master) and the dispatcher (slave).
interface run_dispatcher_if
  import run_dispatch_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int JOB_W = DEF_JOB_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [NUM_W-1:0] cmd_num;
  logic [JOB_W-1:0] cmd_jobs;

  modport master (output cmd_valid, cmd_num, cmd_jobs, input cmd_ready);
  modport slave  (input cmd_valid, cmd_num, cmd_jobs, output cmd_ready);

endinterface

// File: rtl/run_dispatcher_timeout.sv
// WAIT-cycle watchdog: counts enabled cycles since clear, flags the TO_CYCLES-th one.
// Only built when RUN_DISPATCHER_TIMEOUT_EN is defined.
`ifdef RUN_DISPATCHER_TIMEOUT_EN
module run_timeout
  import run_dispatch_pkg::*;
#(
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt;

  // tc is combinational so a same-cycle wk_done can still win over it.
  assign tc = enable && (cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (enable && !tc)    cnt <= cnt + CW'(1);
  end

endmodule
`endif

// File: rtl/run_dispatcher.sv
// Launches cmd_jobs worker runs of size cmd_num, one at a time, then pulses done.
// Optional WAIT timeout enabled by defining RUN_DISPATCHER_TIMEOUT_EN.
module run_dispatcher
  import run_dispatch_pkg::*;
#(
  parameter int NUM_W     = DEF_NUM_W,
  parameter int JOB_W     = DEF_JOB_W,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  run_dispatcher_if.slave  cmd,
  output logic             wk_run,
  output logic [NUM_W-1:0] wk_num,
  input  logic             wk_done,
  output logic             busy,
  output logic [JOB_W-1:0] jobs_done,
  output logic             done,
  output logic             err
);

  run_state_e       state;
  logic [JOB_W-1:0] jobs_lat;
  logic [JOB_W-1:0] jobs_nxt;

  assign jobs_nxt = jobs_done + JOB_W'(1);

`ifdef RUN_DISPATCHER_TIMEOUT_EN
  logic to_hit;

  run_timeout #(.TO_CYCLES(TO_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_LAUNCH),
    .enable  (state == ST_WAIT),
    .tc      (to_hit)
  );
`else
  assign err = 1'b0;
`endif

  // All outputs are registered and move together with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cmd.cmd_ready <= 1'b1;
      wk_run        <= 1'b0;
      wk_num        <= '0;
      jobs_lat      <= '0;
      jobs_done     <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
`ifdef RUN_DISPATCHER_TIMEOUT_EN
      err           <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            wk_num        <= cmd.cmd_num;
            jobs_lat      <= cmd.cmd_jobs;
            jobs_done     <= '0;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
`ifdef RUN_DISPATCHER_TIMEOUT_EN
            err           <= 1'b0;
`endif
            // An empty command still reports completion, just without launches.
            if (cmd.cmd_jobs != '0 && cmd.cmd_num != '0) begin
              state  <= ST_LAUNCH;
              wk_run <= 1'b1;
            end else begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          wk_run <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wk_done) begin
            jobs_done <= jobs_nxt;
            if (jobs_nxt == jobs_lat) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state  <= ST_LAUNCH;
              wk_run <= 1'b1;
            end
          end
`ifdef RUN_DISPATCHER_TIMEOUT_EN
          else if (to_hit) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
`endif
        end
        ST_FINISH: begin
          done          <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= ST_IDLE;
        end
`ifdef RUN_DISPATCHER_TIMEOUT_EN
        ST_ERR: begin
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= ST_IDLE;
        end
`endif
        default: begin
          state         <= ST_IDLE;
          cmd.cmd_ready <= 1'b1;
          busy          <= 1'b0;
          wk_run        <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_dispatcher.sv
// Scoreboard bench for run_dispatcher; timeout scenarios run when RUN_DISPATCHER_TIMEOUT_EN is defined.
module tb_run_dispatcher;
  import run_dispatch_pkg::*;

  localparam int NUM_W = 4;
  localparam int JOB_W = 4;
`ifdef RUN_DISPATCHER_TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_CYCLES = 64;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wk_run, wk_done, busy, done, err;
  logic [NUM_W-1:0] wk_num;
  logic [JOB_W-1:0] jobs_done;
  logic             wk_done_w = 1'b0;
  logic             wk_done_p = 1'b0;

  assign wk_done = wk_done_w | wk_done_p;

  run_dispatcher_if #(.NUM_W(NUM_W), .JOB_W(JOB_W)) cif ();

  run_dispatcher #(.NUM_W(NUM_W), .JOB_W(JOB_W), .TO_CYCLES(TO_CYCLES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (cif.slave),
    .wk_run    (wk_run),
    .wk_num    (wk_num),
    .wk_done   (wk_done),
    .busy      (busy),
    .jobs_done (jobs_done),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {int num; int jobs; int runs;} exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, run_cnt = 0, done_cnt = 0, done_cyc = -1, acc_cyc = -1;
  int worker_dly = 6, cd = -1;
  bit worker_en = 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Worker model: answers each wk_run with a wk_done worker_dly cycles later.
  always @(negedge clk) begin
    wk_done_w = 1'b0;
    if (!reset_n) cd = -1;
    else begin
      if (cd > 0) cd--;
      if (cd == 0) begin wk_done_w = 1'b1; cd = -1; end
      if (wk_run && worker_en) cd = worker_dly;
    end
  end

  // Monitor: checks each launch and pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) run_cnt = 0;
    else begin
      if (wk_run) begin
        if (sb.size() > 0) chk("wk_num_at_run", int'(wk_num), sb[0].num);
        chk("jobs_done_at_run", int'(jobs_done), run_cnt);
        run_cnt++;
      end
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("jobs_done_final", int'(jobs_done), e.runs);
          chk("run_count", run_cnt, e.runs);
          chk("wk_num_at_done", int'(wk_num), e.num);
          chk("err_at_done", int'(err), 0);
        end
        run_cnt = 0;
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int num, input int jobs);
    exp_t e;
    int b;
    cif.cmd_valid = 1'b1;
    cif.cmd_num   = num[NUM_W-1:0];
    cif.cmd_jobs  = jobs[JOB_W-1:0];
    e.num = num; e.jobs = jobs;
    e.runs = (num != 0 && jobs != 0) ? jobs : 0;
    sb.push_back(e);
    b = 0;
    while (!cif.cmd_ready && b < 200) begin @(negedge clk); b++; end
    if (!cif.cmd_ready) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int lim);
    int b;
    b = 0;
    while (done_cnt < target && b < lim) begin @(posedge clk); b++; end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    @(negedge clk);
  endtask

  initial begin
    int n, dc;
    cif.cmd_valid = 1'b0; cif.cmd_num = '0; cif.cmd_jobs = '0;
    @(negedge clk);
    chk("rst_ready", int'(cif.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wk_run", int'(wk_run), 0);
    chk("rst_jobs_done", int'(jobs_done), 0);
    chk("rst_wk_num", int'(wk_num), 0);
    chk("rst_done_err", int'({done, err}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Three jobs of size 5, worker answers after 6 cycles.
    worker_en = 1'b1; worker_dly = 6;
    issue(5, 3); cif.cmd_valid = 1'b0;
    wait_done(1, 200);

    // wk_done in IDLE must not touch the held count.
    wk_done_p = 1'b1; @(negedge clk); wk_done_p = 1'b0;
    chk("idle_poke_jobs", int'(jobs_done), 3);
    chk("idle_poke_busy", int'(busy), 0);
    chk("idle_poke_ready", int'(cif.cmd_ready), 1);

    // wk_done in LAUNCH ignored; then two manual completions in WAIT.
    worker_en = 1'b0;
    issue(5, 2); cif.cmd_valid = 1'b0;
    chk("launch_wk_run", int'(wk_run), 1);
    wk_done_p = 1'b1; @(negedge clk); wk_done_p = 1'b0;
    chk("launch_poke_jobs", int'(jobs_done), 0);
    chk("launch_poke_state", int'({wk_run, busy}), 1);
    repeat (2) @(negedge clk);
    wk_done_p = 1'b1; @(negedge clk); wk_done_p = 1'b0;
    chk("wait_poke_jobs", int'(jobs_done), 1);
    chk("wait_poke_relaunch", int'(wk_run), 1);
    @(negedge clk);
    wk_done_p = 1'b1; @(negedge clk); wk_done_p = 1'b0;
    chk("wait_poke_done", int'(done), 1);
    worker_en = 1'b1;
    @(negedge clk);

    // Empty commands: FINISH only, busy for one cycle.
    issue(3, 0); cif.cmd_valid = 1'b0;
    chk("empty_finish", int'({busy, done, wk_run}), 3'b110);
    @(negedge clk);
    chk("empty_idle", int'({busy, done, cif.cmd_ready}), 3'b001);
    issue(0, 2); cif.cmd_valid = 1'b0;
    chk("zero_num_finish", int'({busy, done, wk_run}), 3'b110);
    wait_done(4, 20);

    // Back-to-back with cmd_valid held.
    worker_dly = 2;
    issue(6, 1); issue(9, 2); cif.cmd_valid = 1'b0;
    chk("b2b_accept_cycle", acc_cyc, done_cyc + 1);
    wait_done(6, 100);

    // Reset during the second of four jobs.
    worker_dly = 3;
    issue(7, 4); cif.cmd_valid = 1'b0;
    n = 0;
    while (run_cnt < 2 && n < 100) begin @(posedge clk); n++; end
    chk("second_launch_seen", run_cnt, 2);
    @(negedge clk);
    dc = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_outputs", int'({wk_run, busy, done, err}), 0);
    chk("mid_rst_wk_num", int'(wk_num), 0);
    chk("mid_rst_jobs_done", int'(jobs_done), 0);
    chk("mid_rst_ready", int'(cif.cmd_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_cnt, dc);
    issue(2, 2); cif.cmd_valid = 1'b0;
    wait_done(dc + 1, 100);

`ifdef RUN_DISPATCHER_TIMEOUT_EN
    // Silent worker: ERR after TO_CYCLES WAIT cycles, no done.
    worker_en = 1'b0;
    dc = done_cnt;
    issue(4, 1); cif.cmd_valid = 1'b0;
    n = 0;
    while (!err && n < 40) begin @(negedge clk); n++; end
    chk("to_latency", n, TO_CYCLES + 1);
    @(negedge clk);
    chk("to_err_sticky", int'({err, busy, cif.cmd_ready}), 3'b101);
    chk("to_no_done", done_cnt, dc);
    sb.delete();
    // wk_done on the terminal WAIT cycle wins; accept clears err.
    worker_en = 1'b1; worker_dly = TO_CYCLES;
    issue(4, 1); cif.cmd_valid = 1'b0;
    chk("to_err_cleared", int'(err), 0);
    wait_done(dc + 1, 100);
    chk("to_edge_no_err", int'(err), 0);
`else
    chk("err_tied_low", int'(err), 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
